// File: rtl/gbproc_core.sv
// gbproc_core: 8-register accumulator core with an ALU, register copies and a probe of {A, F}.
// Optional build macro GBPROC_CORE_IMM_EN: ALU source 6 takes the next accepted word as an immediate.
module gbproc_core #(
    parameter int DATA_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     instruction,
    input  logic                  valid,
    output logic                  ready,
    output logic                  done,
    output logic [2*DATA_W-1:0]   probe
);

    // Slot 6 of the file is the flag register; as a copy/source index, 6 means "special".
    localparam logic [2:0] IDX_F = 3'd6;
    localparam logic [2:0] IDX_A = 3'd7;
    localparam logic [2:0] OP_CP = 3'd7;

`ifdef GBPROC_CORE_IMM_EN
    typedef enum logic {FETCH, IMM} state_t;
    logic [2:0] pend_op;
`else
    typedef enum logic {FETCH} state_t;
    logic unused_instr;
    assign unused_instr = ^instruction;
`endif

    state_t          state;
    logic [DATA_W-1:0] rf [8];

    logic [7:0]        opcode;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_src;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   wide;
    logic [4:0]        nib;
    logic              cin;
    logic              ci;
    logic              flag_z;
    logic              flag_n;
    logic              flag_h;
    logic              flag_c;
    logic              do_alu;
    logic              do_copy;
    logic              go_imm;
    logic              accept;

    assign opcode = instruction[7:0];
    assign accept = valid & ready;
    assign probe  = {rf[IDX_A], rf[IDX_F]};
    assign alu_a  = rf[IDX_A];
    assign cin    = rf[IDX_F][DATA_W-4];

    always_comb begin
        alu_op  = opcode[5:3];
        alu_src = (opcode[2:0] == IDX_F) ? '0 : rf[opcode[2:0]];
        do_alu  = (opcode[7:6] == 2'b10);
        do_copy = (opcode[7:6] == 2'b01) && (opcode[5:3] != IDX_F) && (opcode[2:0] != IDX_F);
        go_imm  = 1'b0;
`ifdef GBPROC_CORE_IMM_EN
        if (state == IMM) begin
            alu_op  = pend_op;
            alu_src = instruction;
            do_alu  = 1'b1;
            do_copy = 1'b0;
        end else if (do_alu && (opcode[2:0] == IDX_F)) begin
            do_alu  = 1'b0;
            go_imm  = 1'b1;
        end
`endif
    end

    // Subtraction in one extra bit: the top bit of each difference is the borrow.
    always_comb begin
        ci      = 1'b0;
        wide    = '0;
        nib     = '0;
        alu_res = '0;
        flag_h  = 1'b0;
        flag_c  = 1'b0;
        flag_n  = 1'b0;
        case (alu_op)
            3'd0, 3'd1: begin
                ci      = alu_op[0] & cin;
                wide    = {1'b0, alu_a} + {1'b0, alu_src} + {{DATA_W{1'b0}}, ci};
                nib     = {1'b0, alu_a[3:0]} + {1'b0, alu_src[3:0]} + {4'b0000, ci};
                alu_res = wide[DATA_W-1:0];
                flag_h  = nib[4];
                flag_c  = wide[DATA_W];
            end
            3'd2, 3'd3, 3'd7: begin
                ci      = (alu_op == 3'd3) & cin;
                wide    = {1'b0, alu_a} - {1'b0, alu_src} - {{DATA_W{1'b0}}, ci};
                nib     = {1'b0, alu_a[3:0]} - {1'b0, alu_src[3:0]} - {4'b0000, ci};
                alu_res = wide[DATA_W-1:0];
                flag_h  = nib[4];
                flag_c  = wide[DATA_W];
                flag_n  = 1'b1;
            end
            3'd4: begin
                alu_res = alu_a & alu_src;
                flag_h  = 1'b1;
            end
            3'd5:    alu_res = alu_a ^ alu_src;
            default: alu_res = alu_a | alu_src;
        endcase
        flag_z = (alu_res == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf[0] <= DATA_W'(1);
            rf[1] <= DATA_W'(2);
            rf[2] <= DATA_W'(3);
            rf[3] <= DATA_W'(4);
            rf[4] <= DATA_W'(5);
            rf[5] <= DATA_W'(6);
            rf[6] <= '0;
            rf[7] <= '0;
            state <= FETCH;
            ready <= 1'b0;
            done  <= 1'b0;
`ifdef GBPROC_CORE_IMM_EN
            pend_op <= '0;
`endif
        end else begin
`ifdef GBPROC_CORE_IMM_EN
            ready <= 1'b1;
`else
            ready <= (state == FETCH);
`endif
            done  <= 1'b0;
            if (accept) begin
                done <= ~go_imm;
                if (do_alu) begin
                    if (alu_op != OP_CP)
                        rf[IDX_A] <= alu_res;
                    rf[IDX_F] <= {flag_z, flag_n, flag_h, flag_c, {(DATA_W-4){1'b0}}};
                end
                if (do_copy)
                    rf[opcode[5:3]] <= rf[opcode[2:0]];
`ifdef GBPROC_CORE_IMM_EN
                if (go_imm)
                    pend_op <= opcode[5:3];
                state <= go_imm ? IMM : FETCH;
`endif
            end
        end
    end

endmodule
